arcade_start_seq: RTL



---
 rtl/arcade_input_pkg.sv | 27 ++
 rtl/arcade_phase_timer.sv | 28 ++
 rtl/arcade_start_seq.sv | 124 ++++++++++++
 3 files changed

// File: rtl/arcade_input_pkg.sv
// Shared definitions for the arcade coin/start sequencer: FSM states,
// default phase lengths and the channel picker.
package arcade_input_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COIN,
    GAP,
    START,
    RELEASE
  } seq_state_e;

  localparam int DEF_COIN_LEN  = 100;
  localparam int DEF_GAP_LEN   = 700;
  localparam int DEF_START_LEN = 800;

  // Lowest set index wins, so player 1 is always served before player 2.
  function automatic logic [1:0] lowest_set(input logic [3:0] req);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arcade_phase_timer.sv
// Tick-driven down counter shared by every timed phase of the sequencer.
module arcade_phase_timer #(
  parameter int CW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] len,
  input  logic          tick,
  output logic          done
);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= len;
    end else if (tick && count != '0) begin
      count <= count - CW'(1);
    end
  end

  // The last tick of a phase is the one that sees the count at 1.
  assign done = tick && (count == CW'(1));

endmodule

// File: rtl/arcade_start_seq.sv
// Arbitrated coin/start sequencer: queues button edges and plays them out
// as timed active-low coin and start pulses on the game input bus.
module arcade_start_seq
  import arcade_input_pkg::*;
#(
  parameter int NPLAYERS  = 2,
  parameter int AUTO_COIN = 1,
  parameter int CW        = 12,
  parameter int COIN_LEN  = DEF_COIN_LEN,
  parameter int GAP_LEN   = DEF_GAP_LEN,
  parameter int START_LEN = DEF_START_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic [NPLAYERS-1:0] start_req,
  input  logic                coin_req,
  output logic                coin_n,
  output logic [NPLAYERS-1:0] start_n,
  output logic                busy,
  output logic [NPLAYERS-1:0] pending
);

  localparam int SELW = (NPLAYERS > 1) ? $clog2(NPLAYERS) : 1;

  seq_state_e          state, state_next;
  logic [SELW-1:0]     sel, sel_next;
  logic                from_start, from_start_next;
  logic [NPLAYERS-1:0] start_q, start_edge, pend_clr, start_dec;
  logic                coin_q, coin_edge, coin_pend, coin_clr;
  logic [3:0]          pend4;
  logic                sel_held, enter, phase_done;
  logic [CW-1:0]       phase_len;

  assign start_edge = start_req & ~start_q;
  assign coin_edge  = coin_req & ~coin_q;
  assign busy       = (state != IDLE);

  always_comb begin
    pend4 = '0;
    pend4[NPLAYERS-1:0] = pending;
    sel_held = 1'b0;
    for (int i = 0; i < NPLAYERS; i++) begin
      if (sel == SELW'(i)) sel_held = start_req[i];
    end
  end

  always_comb begin
    state_next      = state;
    sel_next        = sel;
    from_start_next = from_start;
    case (state)
      IDLE: begin
        if (|pending) begin
          sel_next        = SELW'(lowest_set(pend4));
          from_start_next = 1'b1;
          state_next      = (AUTO_COIN != 0) ? COIN : START;
        end else if (coin_pend) begin
          from_start_next = 1'b0;
          state_next      = COIN;
        end
      end
      COIN:    if (phase_done) state_next = from_start ? GAP : IDLE;
      GAP:     if (phase_done) state_next = START;
      START:   if (phase_done) state_next = RELEASE;
      RELEASE: if (!sel_held)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Queue bookkeeping: a start clears only when its pulse actually begins,
  // and an auto-coin pulse leaves a manually inserted coin untouched.
  always_comb begin
    enter     = (state_next != state);
    phase_len = '0;
    case (state_next)
      COIN:    phase_len = CW'(COIN_LEN);
      GAP:     phase_len = CW'(GAP_LEN);
      START:   phase_len = CW'(START_LEN);
      default: phase_len = '0;
    endcase
    coin_clr = enter && (state_next == COIN) && !from_start_next;
    for (int i = 0; i < NPLAYERS; i++) begin
      pend_clr[i]  = enter && (state_next == START) && (sel_next == SELW'(i));
      start_dec[i] = !((state == START) && (sel == SELW'(i)));
    end
  end

  arcade_phase_timer #(
    .CW(CW)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .load(enter),
    .len (phase_len),
    .tick(tick),
    .done(phase_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sel        <= '0;
      from_start <= 1'b0;
      start_q    <= '0;
      coin_q     <= 1'b0;
      pending    <= '0;
      coin_pend  <= 1'b0;
      coin_n     <= 1'b1;
      start_n    <= '1;
    end else begin
      state      <= state_next;
      sel        <= sel_next;
      from_start <= from_start_next;
      start_q    <= start_req;
      coin_q     <= coin_req;
      pending    <= (pending | start_edge) & ~pend_clr;
      coin_pend  <= (coin_pend | coin_edge) & ~coin_clr;
      coin_n     <= (state != COIN);
      start_n    <= start_dec;
    end
  end

endmodule
